fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined RV64 core; feeds the IF/ID boundary consumed by decode.
- Owns the PC register, the next-PC mux (sequential, stall, branch redirect) and the IF/ID pipeline register.
- Detects the all-zero halt word, drains the pipeline and raises end_program for the testbench.

---
 rtl/fetch_stage.sv | 171 +++++++++++++++++
 tb/tb_fetch_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV64 instruction-fetch stage: PC, next-PC mux, IF/ID register, halt drain
//
// Purpose:
//   Owns the fetch PC and the IF/ID pipeline register. It selects the next PC from a
//   branch redirect, a stall hold, or sequential PC+4. It also watches for the all-zero
//   halt word. When it sees one, it feeds bubbles for DRAIN_CYCLES edges so the older
//   instructions can retire, then raises a sticky end_program.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   stall              load-use stall from the hazard unit (hold PC and IF/ID)
//   flush              taken branch resolved downstream (redirect PC, squash IF/ID)
//   branch_target      redirect address, used when flush=1
//   imem_addr          instruction memory byte address (= pc_current)
//   imem_rdata         combinational instruction word at imem_addr
//   pc_current         current fetch PC
//   instruction        imem_rdata passthrough for trace
//   if_id_pc/instr     IF/ID register contents
//   if_id_valid        1 = real instruction, 0 = bubble
//   end_program        sticky; program finished and pipeline drained
//   perf_*             (only with FETCH_PERF_EN) saturating 32-bit event counters
//
// Optional feature: define FETCH_PERF_EN to add perf_cycles, perf_fetched,
// perf_stalls and perf_flushes.
module fetch_stage #(
  parameter int               XLEN         = 64,
  parameter logic [XLEN-1:0]  RESET_PC     = '0,
  parameter int               DRAIN_CYCLES = 4,
  parameter logic [31:0]      NOP_WORD     = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc_current,
  output logic [31:0]     instruction,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid,
`ifdef FETCH_PERF_EN
  output logic [31:0]     perf_cycles,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stalls,
  output logic [31:0]     perf_flushes,
`endif
  output logic            end_program
);

  // The counter only ever holds DRAIN_CYCLES-1 down to 0.
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   if_id_pc_q, if_id_pc_d;
  logic [31:0]       if_id_instr_q, if_id_instr_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic              end_q, end_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_WORD;
      if_id_valid_q <= 1'b0;
      end_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      end_q         <= end_d;
    end
  end

  // Bubbles change only the instruction and valid bit. if_id_pc keeps its old value
  // because decode ignores it when valid is low.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    end_d         = end_q;
    case (state_q)
      RUN: begin
        if (flush) begin
          // A redirect beats a stall. The word fetched this cycle is on the wrong path.
          pc_d          = branch_target;
          if_id_instr_d = NOP_WORD;
          if_id_valid_d = 1'b0;
        end else if (stall) begin
          // Hold everything.
        end else if (imem_rdata == 32'h0) begin
          if_id_instr_d = NOP_WORD;
          if_id_valid_d = 1'b0;
          cnt_d         = CNT_W'(DRAIN_CYCLES - 1);
          state_d       = DRAIN;
        end else begin
          pc_d          = pc_q + XLEN'(4);
          if_id_pc_d    = pc_q;
          if_id_instr_d = imem_rdata;
          if_id_valid_d = 1'b1;
        end
      end
      DRAIN: begin
        if_id_instr_d = NOP_WORD;
        if_id_valid_d = 1'b0;
        if (flush) begin
          // An older branch was taken, so the halt word was speculative. Resume fetching.
          pc_d    = branch_target;
          cnt_d   = '0;
          state_d = RUN;
        end else if (cnt_q == '0) begin
          end_d   = 1'b1;
          state_d = HALTED;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HALTED: begin
        // Frozen until reset.
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign pc_current  = pc_q;
  assign instruction = imem_rdata;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
  assign end_program = end_q;

`ifdef FETCH_PERF_EN
  logic inc_cycle, inc_fetch, inc_stall, inc_flush;

  assign inc_cycle = (state_q != HALTED);
  assign inc_fetch = (state_q == RUN) && !flush && !stall && (imem_rdata != 32'h0);
  assign inc_stall = (state_q == RUN) && !flush && stall;
  assign inc_flush = (state_q != HALTED) && flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles  <= '0;
      perf_fetched <= '0;
      perf_stalls  <= '0;
      perf_flushes <= '0;
    end else begin
      if (inc_cycle && (perf_cycles  != '1)) perf_cycles  <= perf_cycles  + 32'd1;
      if (inc_fetch && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
      if (inc_stall && (perf_stalls  != '1)) perf_stalls  <= perf_stalls  + 32'd1;
      if (inc_flush && (perf_flushes != '1)) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [63:0] branch_target;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [63:0] pc_current;
  logic [31:0] instruction;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        end_program;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_cycles, perf_fetched, perf_stalls, perf_flushes;
`endif

  logic [31:0] mem [0:63];
  int          passes = 0;
  int          fails  = 0;
  int          total  = 0;

  assign imem_rdata = mem[imem_addr[7:2]];

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .pc_current    (pc_current),
    .instruction   (instruction),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
`ifdef FETCH_PERF_EN
    .perf_cycles   (perf_cycles),
    .perf_fetched  (perf_fetched),
    .perf_stalls   (perf_stalls),
    .perf_flushes  (perf_flushes),
`endif
    .end_program   (end_program)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int i);
    return 32'h00000093 | (32'(i) << 20);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [63:0] pc, input logic [31:0] ins);
    check({tag, " if_id_pc"}, if_id_pc, pc);
    check({tag, " if_id_instr"}, {32'h0, if_id_instr}, {32'h0, ins});
    check({tag, " if_id_valid"}, {63'h0, if_id_valid}, 64'd1);
  endtask

  task automatic check_bubble(input string tag);
    check({tag, " bubble instr"}, {32'h0, if_id_instr}, 64'h13);
    check({tag, " bubble valid"}, {63'h0, if_id_valid}, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = word(i);
    mem[0]  = 32'h00300093;
    mem[1]  = 32'h00700113;
    mem[2]  = 32'h00a00193;
    mem[6]  = 32'h0;          // halt word at 0x18
    mem[10] = 32'h0;          // halt word at 0x28

    reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = '0;
    step(); step();
    check("reset pc", pc_current, 64'h0);
    check("reset imem_addr", imem_addr, 64'h0);
    check("reset if_id_pc", if_id_pc, 64'h0);
    check_bubble("reset");
    check("reset end", {63'h0, end_program}, 64'd0);

    // Sequential fetch
    reset = 1'b0;
    step();
    check_ifid("seq0", 64'h0, 32'h00300093);
    check("seq0 pc", pc_current, 64'h4);
    step();
    check_ifid("seq1", 64'h4, 32'h00700113);
    check("seq1 pc", pc_current, 64'h8);
    check("trace instruction", {32'h0, instruction}, 64'h00a00193);

    // Stall for two cycles
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall pc", pc_current, 64'h8);
      check_ifid("stall", 64'h4, 32'h00700113);
    end
    stall = 1'b0;
    step();
    check_ifid("post-stall", 64'h8, 32'h00a00193);
    check("post-stall pc", pc_current, 64'hc);

    // Flush wins over stall
    flush = 1'b1; stall = 1'b1; branch_target = 64'h20;
    step();
    check("flush pc", pc_current, 64'h20);
    check_bubble("flush");
    flush = 1'b0; stall = 1'b0;
    step();
    check_ifid("after flush", 64'h20, word(8));
    check("after flush pc", pc_current, 64'h24);

    // Redirect to 0x10, then run into the halt word at 0x18
    flush = 1'b1; branch_target = 64'h10;
    step();
    check("redir pc", pc_current, 64'h10);
    flush = 1'b0;
    step();
    check_ifid("f10", 64'h10, word(4));
    step();
    check_ifid("f14", 64'h14, word(5));
    check("halt pc", pc_current, 64'h18);
    check("halt word seen", {32'h0, instruction}, 64'h0);
    step();
    check("detect pc", pc_current, 64'h18);
    check_bubble("detect");
    check("detect end", {63'h0, end_program}, 64'd0);
    stall = 1'b1;   // ignored while draining
    for (int i = 1; i <= 3; i++) begin
      step();
      check("drain pc", pc_current, 64'h18);
      check_bubble("drain");
      check("drain end", {63'h0, end_program}, 64'd0);
    end
    step();
    check("end on 4th edge", {63'h0, end_program}, 64'd1);
    stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      flush = i[0]; branch_target = 64'h40;
      step();
      check("halted end", {63'h0, end_program}, 64'd1);
      check("halted pc", pc_current, 64'h18);
    end
    flush = 1'b0;

    // Reset out of HALTED
    reset = 1'b1;
    step();
    check("rehalt pc", pc_current, 64'h0);
    check("rehalt end", {63'h0, end_program}, 64'd0);
    check("rehalt valid", {63'h0, if_id_valid}, 64'd0);
    reset = 1'b0;

    // PC wrap at the top of the address space
    flush = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    check("wrap target", pc_current, 64'hFFFF_FFFF_FFFF_FFFC);
    flush = 1'b0;
    step();
    check_ifid("wrap fetch", 64'hFFFF_FFFF_FFFF_FFFC, word(63));
    check("wrap pc", pc_current, 64'h0);

    // Halt cancelled by a flush on the second drain cycle
    flush = 1'b1; branch_target = 64'h14;
    step();
    flush = 1'b0;
    step();
    check_ifid("c14", 64'h14, word(5));
    step();
    check("cancel detect pc", pc_current, 64'h18);
    step();
    check("cancel drain1 end", {63'h0, end_program}, 64'd0);
    flush = 1'b1; branch_target = 64'h8;
    step();
    check("cancel pc", pc_current, 64'h8);
    check_bubble("cancel");
    check("cancel end", {63'h0, end_program}, 64'd0);
    flush = 1'b0;
    step();
    check_ifid("resume", 64'h8, 32'h00a00193);
    check("resume pc", pc_current, 64'hc);
    step();
    check("resume end a", {63'h0, end_program}, 64'd0);
    step();
    check("resume pc b", pc_current, 64'h14);
    check("resume end b", {63'h0, end_program}, 64'd0);

`ifdef FETCH_PERF_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("perf reset", {32'h0, perf_cycles}, 64'd0);
    step(); step();                   // fetch 0x0, 0x4
    stall = 1'b1; step(); step();     // two stalls
    stall = 1'b0; step(); step();     // fetch 0x8, 0xc
    flush = 1'b1; branch_target = 64'h20;
    step();                           // one flush
    flush = 1'b0; step(); step();     // fetch 0x20, 0x24
    step();                           // halt at 0x28
    for (int i = 0; i < 4; i++) step();
    check("perf end", {63'h0, end_program}, 64'd1);
    for (int i = 0; i < 3; i++) step();
    check("perf_fetched", {32'h0, perf_fetched}, 64'd6);
    check("perf_stalls", {32'h0, perf_stalls}, 64'd2);
    check("perf_flushes", {32'h0, perf_flushes}, 64'd1);
    check("perf_cycles", {32'h0, perf_cycles}, 64'd14);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
